// File: rtl/riscv_structures.sv
// Shared arbiter types: FSM state encoding and port ownership.
package riscv_structures;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data port by default, fetch when alone or starved.
module mem_arb_pick
  import riscv_structures::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CntW       = $clog2(STARVE_MAX + 1)
) (
  input  logic            if_req,
  input  logic            dm_req,
  input  logic [CntW-1:0] starve_cnt,
  output arb_owner_e      winner
);

  always_comb begin
    winner = OWN_DM;
    if (if_req && (!dm_req || (starve_cnt == CntW'(STARVE_MAX)))) begin
      winner = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port memory, one transaction in flight.
module mem_arbiter
  import riscv_structures::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            dm_store_q, dm_store_d;
  arb_owner_e      winner;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX),
    .CntW      (CntW)
  ) u_pick (
    .if_req    (if_req),
    .dm_req    (dm_req),
    .starve_cnt(starve_cnt_q),
    .winner    (winner)
  );

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    dm_store_d   = dm_store_q;
    if_gnt       = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    dm_gnt       = 1'b0;
    dm_rvalid    = 1'b0;
    dm_rdata     = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;

    unique case (state_q)
      IDLE: begin
        mem_req = if_req | dm_req;
        if (winner == OWN_IF) begin
          mem_addr = if_addr;
          mem_be   = 4'hF;
        end else begin
          mem_we    = dm_we;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
          mem_be    = dm_be;
        end
        if (mem_req && mem_ready) begin
          if (winner == OWN_IF) begin
            if_gnt       = 1'b1;
            state_d      = BUSY_IF;
            starve_cnt_d = '0;
          end else begin
            dm_gnt     = 1'b1;
            state_d    = BUSY_DM;
            dm_store_d = dm_we;
            if (if_req && (starve_cnt_q != CntW'(STARVE_MAX))) begin
              starve_cnt_d = starve_cnt_q + CntW'(1);
            end
          end
        end
      end
      BUSY_IF: begin
        if (mem_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
          state_d   = IDLE;
        end
      end
      BUSY_DM: begin
        if (mem_rvalid) begin
          dm_rvalid = 1'b1;
          // Store completions never expose memory read data.
          dm_rdata  = dm_store_q ? '0 : mem_rdata;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced low for the whole time reset is held.
    if (!reset) begin
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      dm_gnt    = 1'b0;
      dm_rvalid = 1'b0;
      dm_rdata  = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      dm_store_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      dm_store_q   <= dm_store_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: is a transaction outstanding, who owns it, was it a store, fetch-skip count.
  bit m_busy, m_own_dm, m_store;
  int m_starve;

  // Expected values for the current cycle.
  logic        e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_req, e_we, e_acc, e_fetch;
  logic [31:0] e_if_rd, e_dm_rd, e_addr, e_wdata;
  logic [3:0]  e_be;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict this cycle's outputs from the model and compare every output.
  task automatic settle_check();
    #1;
    {e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_req, e_we, e_acc, e_fetch} = '0;
    {e_if_rd, e_dm_rd, e_addr, e_wdata, e_be} = '0;
    if (reset) begin
      if (!m_busy) begin
        e_req   = if_req | dm_req;
        e_fetch = if_req && (!dm_req || m_starve == STARVE);
        if (e_fetch) begin
          e_addr = if_addr;
          e_be   = 4'hF;
        end else begin
          e_we    = dm_we;
          e_addr  = dm_addr;
          e_wdata = dm_wdata;
          e_be    = dm_be;
        end
        e_acc    = e_req && mem_ready;
        e_if_gnt = e_acc && e_fetch;
        e_dm_gnt = e_acc && !e_fetch;
      end else if (mem_rvalid) begin
        if (m_own_dm) begin
          e_dm_rv = 1'b1;
          e_dm_rd = m_store ? 32'h0 : mem_rdata;
        end else begin
          e_if_rv = 1'b1;
          e_if_rd = mem_rdata;
        end
      end
    end
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("dm_gnt", dm_gnt, e_dm_gnt);
    chk("if_rvalid", if_rvalid, e_if_rv);
    chk("if_rdata", if_rdata, e_if_rd);
    chk("dm_rvalid", dm_rvalid, e_dm_rv);
    chk("dm_rdata", dm_rdata, e_dm_rd);
    chk("mem_req", mem_req, e_req);
    if (!reset || e_req) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_be", mem_be, e_be);
    end
  endtask

  // Advance the model across the coming rising edge, then return at the next falling edge.
  task automatic tick();
    if (!reset) begin
      m_busy   = 1'b0;
      m_starve = 0;
    end else if (!m_busy) begin
      if (e_acc) begin
        m_busy   = 1'b1;
        m_own_dm = !e_fetch;
        m_store  = dm_we;
        if (e_fetch) m_starve = 0;
        else if (if_req) m_starve = (m_starve + 1 > STARVE) ? STARVE : m_starve + 1;
      end
    end else if (mem_rvalid) begin
      m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  initial begin
    bit pend_if, pend_dm;
    int lat;
    idle_inputs();
    reset = 1'b0;
    // Requests held during reset must not leak to the outputs.
    if_req = 1; dm_req = 1; mem_ready = 1; if_addr = 32'h44; dm_addr = 32'h88;
    @(negedge clk);
    settle_check();
    tick();

    // Fetch only, first acceptance right after reset release.
    reset = 1'b1;
    dm_req = 0; dm_addr = 0; if_addr = 32'h100;
    settle_check();
    chk("fetch_gnt_c0", if_gnt, 1'b1);
    chk("fetch_addr_c0", mem_addr, 32'h100);
    tick();
    if_req = 0;
    settle_check();
    tick();
    mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    settle_check();
    chk("fetch_rvalid_c2", if_rvalid, 1'b1);
    chk("fetch_rdata_c2", if_rdata, 32'h0050_0093);
    chk("fetch_dm_quiet", {dm_rvalid, dm_rdata}, 33'h0);
    tick();

    // Both ports pending continuously: four data wins, then one fetch.
    for (int i = 0; i < 12; i++) begin
      if_req = 1; if_addr = 32'h1000 + i * 4;
      dm_req = 1; dm_we = 0; dm_addr = 32'h3000 + i * 4; dm_be = 4'hF;
      mem_ready = 1; mem_rvalid = 0;
      settle_check();
      chk("starve_order_dm", dm_gnt, (i % 5) != 4);
      chk("starve_order_if", if_gnt, (i % 5) == 4);
      tick();
      mem_rvalid = 1; mem_rdata = $urandom;
      settle_check();
      tick();
    end

    // Store: forwarded fields and zero read data on completion.
    if_req = 0; mem_rvalid = 0;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
    settle_check();
    chk("store_gnt", dm_gnt, 1'b1);
    chk("store_fields", {mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF});
    tick();
    dm_req = 0;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    settle_check();
    chk("store_rvalid", dm_rvalid, 1'b1);
    chk("store_rdata", dm_rdata, 32'h0);
    tick();

    // Memory stalls; request withdrawn before grant leaves no trace.
    mem_rvalid = 0; mem_ready = 0; dm_we = 0; dm_req = 1; dm_addr = 32'h2400;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dm_req = 0;
      settle_check();
      chk("stall_no_gnt", dm_gnt, 1'b0);
      tick();
    end
    mem_ready = 1;
    settle_check();
    chk("dropped_no_req", mem_req, 1'b0);
    tick();

    // Reset in BUSY_DM abandons the transaction; late response dropped.
    dm_req = 1;
    settle_check();
    chk("pre_reset_gnt", dm_gnt, 1'b1);
    tick();
    dm_req = 0;
    settle_check();
    reset = 1'b0;
    #1;
    chk("async_reset_quiet", {dm_rvalid, if_rvalid, mem_req}, 3'b000);
    tick();
    reset = 1'b1;
    mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
    settle_check();
    chk("late_rvalid_dm", dm_rvalid, 1'b0);
    chk("late_rvalid_if", if_rvalid, 1'b0);
    tick();
    mem_rvalid = 0; dm_req = 1; dm_addr = 32'h2800;
    settle_check();
    chk("idle_after_reset", dm_gnt, 1'b1);
    tick();
    dm_req = 0; mem_rvalid = 1;
    settle_check();
    tick();

    // Stray response with no requests.
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    settle_check();
    chk("stray_quiet", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, if_rdata, dm_rdata}, 69'h0);
    tick();

    // Randomized traffic with variable memory latency and stray responses.
    pend_if = 0; pend_dm = 0; lat = 0;
    for (int c = 0; c < 400; c++) begin
      if (pend_if) begin
        if ($urandom_range(0, 9) == 0) if_req = 0;
      end else begin
        if_req = $urandom_range(0, 1); if_addr = $urandom;
      end
      if (pend_dm) begin
        if ($urandom_range(0, 9) == 0) dm_req = 0;
      end else begin
        dm_req = $urandom_range(0, 1); dm_we = $urandom_range(0, 1);
        dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom);
      end
      mem_ready  = ($urandom_range(0, 9) < 7);
      mem_rvalid = m_busy ? (lat == 0) : ($urandom_range(0, 9) == 0);
      mem_rdata  = $urandom;
      if (m_busy && lat > 0) lat--;
      settle_check();
      pend_if = if_req && !e_if_gnt;
      pend_dm = dm_req && !e_dm_gnt;
      tick();
      if (e_acc) lat = $urandom_range(0, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
